// File: rtl/fwd_hazard_unit.sv
`timescale 1ns / 1ps
// fwd_hazard_unit
//   EXE-stage operand forwarding plus pipeline hazard control.
//   - Operand muxes pick RF, MEM-stage (ALU or load data) or WB-stage values.
//   - stall: load-use bubbles (LD_BUBBLES cycles), or RAW stalls in stall-only mode.
//   - freeze: whole pipeline holds while a MEM-stage load waits for mem_rdy.
//   - stall_cnt: saturating count of cycles with stall or freeze asserted.
//   Optional build macro FWD_WB_BYPASS_EN adds an ID-stage write-through capture
//   of wb_data, applied in EXE with fwd_sel = 11.
// Ports:
//   clk, rst (sync, active-low), fwd_en (1 = forwarding, 0 = stall-only)
//   id_*   : ID-stage sources;  exe_* : EXE sources/dest/flags
//   mem_*  : MEM dest/flags/data/mem_rdy;  wb_* : WB dest/enable/data
//   rf_rdata1/2 : RF values latched for EXE
//   opnd1/2, store_data, fwd_sel1/2 : combinational operand selection
//   stall, freeze : combinational pipeline controls;  stall_cnt : perf counter
module fwd_hazard_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned LD_BUBBLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_use_src2,
    input  logic [ADDR_W-1:0] exe_src1,
    input  logic [ADDR_W-1:0] exe_src2,
    input  logic              exe_use_src2,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_rd,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_mem_rd,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              wb_wb_en,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] opnd1,
    output logic [DATA_W-1:0] opnd2,
    output logic [DATA_W-1:0] store_data,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              stall,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

    localparam logic [2:0] LuInit = 3'(LD_BUBBLES - 1);

    // Register 0 is hard-zero: never a forwarding source nor a hazard.
    function automatic logic match(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                                   input logic en);
        return en && (d != '0) && (s == d);
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        bub_q, bub_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem_val;
    logic [1:0]        st_sel;
    logic              m1, w1, m2, w2;
    logic              mem_wait, lu, rh;

`ifdef FWD_WB_BYPASS_EN
    logic              byp1_q, byp2_q;
    logic [DATA_W-1:0] byp_data_q;
`endif

    assign mem_val = mem_mem_rd ? mem_rdata : mem_alu;
    assign m1      = match(exe_src1, mem_dest, mem_wb_en);
    assign w1      = match(exe_src1, wb_dest, wb_wb_en);
    assign m2      = match(exe_src2, mem_dest, mem_wb_en);
    assign w2      = match(exe_src2, wb_dest, wb_wb_en);

    // Operand muxes: MEM beats WB beats RF; all bypassed when fwd_en is low.
    always_comb begin
        fwd_sel1   = 2'b00;
        opnd1      = rf_rdata1;
        st_sel     = 2'b00;
        store_data = rf_rdata2;
        if (fwd_en) begin
            if (m1) begin
                fwd_sel1 = 2'b01;
                opnd1    = mem_val;
            end else if (w1) begin
                fwd_sel1 = 2'b10;
                opnd1    = wb_data;
            end
`ifdef FWD_WB_BYPASS_EN
            else if (byp1_q) begin
                fwd_sel1 = 2'b11;
                opnd1    = byp_data_q;
            end
`endif
            if (m2) begin
                st_sel     = 2'b01;
                store_data = mem_val;
            end else if (w2) begin
                st_sel     = 2'b10;
                store_data = wb_data;
            end
`ifdef FWD_WB_BYPASS_EN
            else if (byp2_q) begin
                st_sel     = 2'b11;
                store_data = byp_data_q;
            end
`endif
        end
        // Store data is forwarded even for immediate-form src2; the ALU operand is not.
        fwd_sel2 = exe_use_src2 ? st_sel : 2'b00;
        opnd2    = exe_use_src2 ? store_data : rf_rdata2;
    end

    assign mem_wait = mem_mem_rd && mem_wb_en && !mem_rdy;
    assign lu = id_valid && exe_mem_rd &&
                (match(id_src1, exe_dest, exe_wb_en) ||
                 (id_use_src2 && match(id_src2, exe_dest, exe_wb_en)));
    assign rh = id_valid &&
                (match(id_src1, exe_dest, exe_wb_en) || match(id_src1, mem_dest, mem_wb_en) ||
                 (id_use_src2 && (match(id_src2, exe_dest, exe_wb_en) ||
                                  match(id_src2, mem_dest, mem_wb_en))));

    // bub_q holds the stall cycles still owed, including the current LU_STALL cycle.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        stall   = 1'b0;
        freeze  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                end else if (fwd_en && lu) begin
                    stall = 1'b1;
                    if (LD_BUBBLES > 1) begin
                        state_d = StLuStall;
                        bub_d   = LuInit;
                    end
                end else if (!fwd_en && rh) begin
                    stall = 1'b1;
                end
            end
            StLuStall: begin
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                end else begin
                    stall = 1'b1;
                    if (bub_q <= 3'd1) begin
                        bub_d   = 3'd0;
                        state_d = StRun;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
            end
            StMemWait: begin
                if (!mem_rdy) begin
                    freeze = 1'b1;
                end else begin
                    state_d = (bub_q != 3'd0) ? StLuStall : StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            bub_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            if ((stall || freeze) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = cnt_q;

`ifdef FWD_WB_BYPASS_EN
    // Captured as the ID instruction advances into EXE; a stall injects a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else if (!freeze) begin
            if (stall) begin
                byp1_q <= 1'b0;
                byp2_q <= 1'b0;
            end else begin
                byp1_q     <= id_valid && match(id_src1, wb_dest, wb_wb_en);
                byp2_q     <= id_valid && match(id_src2, wb_dest, wb_wb_en);
                byp_data_q <= wb_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
`timescale 1ns / 1ps
module tb_fwd_hazard_unit;

    localparam int LDB = 2;
    localparam int CW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en, id_valid, id_use_src2, exe_use_src2, exe_wb_en, exe_mem_rd;
    logic [4:0]  id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic        mem_wb_en, mem_mem_rd, mem_rdy, wb_wb_en;
    logic [31:0] mem_alu, mem_rdata, wb_data, rf_rdata1, rf_rdata2;
    logic [31:0] opnd1, opnd2, store_data;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        stall, freeze;
    logic [CW-1:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: stall cycles still owed, waiting on memory, perf count.
    int lu_left = 0;
    bit waiting = 0;
    int exp_cnt = 0;

    logic [31:0] e_op1, e_op2, e_st;
    logic [1:0]  e_sel1, e_sel2;
    logic        e_stall, e_freeze;

    fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .LD_BUBBLES(LDB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_use_src2(exe_use_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_rd(exe_mem_rd),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_mem_rd(mem_mem_rd),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_data(wb_data),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .opnd1(opnd1), .opnd2(opnd2), .store_data(store_data),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall(stall), .freeze(freeze), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Value a source register should see in EXE: {select, data}.
    function automatic logic [33:0] ref_fwd(input logic [4:0] s, input logic [31:0] rf);
        if (!fwd_en) return {2'b00, rf};
        if (mem_wb_en && mem_dest != 0 && s == mem_dest)
            return {2'b01, mem_mem_rd ? mem_rdata : mem_alu};
        if (wb_wb_en && wb_dest != 0 && s == wb_dest) return {2'b10, wb_data};
        return {2'b00, rf};
    endfunction

    function automatic bit in_flight(input logic [4:0] s);
        return s != 0 && ((exe_wb_en && s == exe_dest) || (mem_wb_en && s == mem_dest));
    endfunction

    function automatic bit load_use();
        return id_valid && exe_mem_rd && exe_wb_en && exe_dest != 0 &&
               (id_src1 == exe_dest || (id_use_src2 && id_src2 == exe_dest));
    endfunction

    function automatic bit raw_hazard();
        return id_valid && (in_flight(id_src1) || (id_use_src2 && in_flight(id_src2)));
    endfunction

    function automatic bit load_waiting();
        return mem_mem_rd && mem_wb_en && !mem_rdy;
    endfunction

    task automatic model_eval();
        logic [33:0] r1, r2;
        r1 = ref_fwd(exe_src1, rf_rdata1);
        r2 = ref_fwd(exe_src2, rf_rdata2);
        e_sel1 = r1[33:32];
        e_op1  = r1[31:0];
        e_st   = r2[31:0];
        e_sel2 = exe_use_src2 ? r2[33:32] : 2'b00;
        e_op2  = exe_use_src2 ? r2[31:0] : rf_rdata2;
        e_stall  = 1'b0;
        e_freeze = 1'b0;
        if (waiting)                       e_freeze = !mem_rdy;
        else if (load_waiting())           e_freeze = 1'b1;
        else if (lu_left > 0)              e_stall  = 1'b1;
        else if (fwd_en && load_use())     e_stall  = 1'b1;
        else if (!fwd_en && raw_hazard())  e_stall  = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    // One clock edge; model follows the same inputs the DUT sampled.
    task automatic adv();
        model_eval();
        @(posedge clk);
        if (!rst) begin
            lu_left = 0;
            waiting = 0;
            exp_cnt = 0;
        end else begin
            if ((e_stall || e_freeze) && exp_cnt < (1 << CW) - 1) exp_cnt++;
            if (waiting) begin
                if (mem_rdy) waiting = 0;
            end else if (load_waiting()) waiting = 1;
            else if (lu_left > 0) lu_left--;
            else if (fwd_en && load_use()) lu_left = LDB - 1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1; fwd_en = 1; id_valid = 0; id_use_src2 = 0; exe_use_src2 = 0;
        exe_wb_en = 0; exe_mem_rd = 0; mem_wb_en = 0; mem_mem_rd = 0; mem_rdy = 1;
        wb_wb_en = 0; id_src1 = 0; id_src2 = 0; exe_src1 = 0; exe_src2 = 0;
        exe_dest = 0; mem_dest = 0; wb_dest = 0; mem_alu = 0; mem_rdata = 0;
        wb_data = 0; rf_rdata1 = 32'h1111_0001; rf_rdata2 = 32'h2222_0002;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        adv();
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_chk++; if (stall_cnt !== 0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        n_chk++; if (stall !== 0 || freeze !== 0) begin
            n_err++; $display("FAIL reset_ctl got stall=%b freeze=%b want 0 0", stall, freeze); end
        n_chk++; if (opnd1 !== rf_rdata1 || fwd_sel1 !== 2'b00) begin
            n_err++; $display("FAIL reset_opnd1 got %h/%b want %h/00", opnd1, fwd_sel1, rf_rdata1); end
        n_chk++; if (opnd2 !== rf_rdata2 || fwd_sel2 !== 2'b00) begin
            n_err++; $display("FAIL reset_opnd2 got %h/%b want %h/00", opnd2, fwd_sel2, rf_rdata2); end
    endtask

    task automatic test_mem_fwd();
        idle();
        exe_src1 = 3; mem_dest = 3; mem_wb_en = 1; mem_alu = 32'hAA;
        settle();
        n_chk++; if (opnd1 !== 32'hAA || fwd_sel1 !== 2'b01 || stall !== 0) begin
            n_err++; $display("FAIL mem_fwd got %h/%b stall=%b want 000000aa/01 0", opnd1, fwd_sel1, stall); end
        adv();
    endtask

    task automatic test_priority();
        idle();
        mem_dest = 4; mem_wb_en = 1; mem_alu = 32'h11;
        wb_dest = 4; wb_wb_en = 1; wb_data = 32'h22;
        exe_src1 = 4; exe_src2 = 4; exe_use_src2 = 0;
        settle();
        n_chk++; if (opnd1 !== 32'h11 || fwd_sel1 !== 2'b01) begin
            n_err++; $display("FAIL prio_mem got %h/%b want 00000011/01", opnd1, fwd_sel1); end
        n_chk++; if (opnd2 !== rf_rdata2 || fwd_sel2 !== 2'b00 || store_data !== 32'h11) begin
            n_err++; $display("FAIL prio_imm got %h/%b st=%h want %h/00 st=00000011",
                              opnd2, fwd_sel2, store_data, rf_rdata2); end
        adv();
        mem_wb_en = 0; exe_use_src2 = 1;
        settle();
        n_chk++; if (opnd1 !== 32'h22 || fwd_sel1 !== 2'b10 || opnd2 !== 32'h22 || fwd_sel2 !== 2'b10) begin
            n_err++; $display("FAIL prio_wb got %h/%b %h/%b want 00000022/10 twice",
                              opnd1, fwd_sel1, opnd2, fwd_sel2); end
        adv();
        mem_wb_en = 1; mem_dest = 0; wb_dest = 0; exe_src1 = 0; exe_src2 = 0;
        settle();
        n_chk++; if (fwd_sel1 !== 2'b00 || fwd_sel2 !== 2'b00 || opnd1 !== rf_rdata1) begin
            n_err++; $display("FAIL prio_r0 got %b %b %h want 00 00 %h", fwd_sel1, fwd_sel2, opnd1, rf_rdata1); end
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid = 1; id_src2 = 5; id_use_src2 = 1;
        exe_dest = 5; exe_wb_en = 1; exe_mem_rd = 1;
        for (int c = 0; c < LDB; c++) begin
            settle();
            n_chk++; if (stall !== 1 || freeze !== 0) begin
                n_err++; $display("FAIL lu_stall cyc %0d got stall=%b freeze=%b want 1 0", c, stall, freeze); end
            adv();
            exe_dest = 0; exe_wb_en = 0; exe_mem_rd = 0;
        end
        id_valid = 0;
        exe_src2 = 5; exe_use_src2 = 1;
        mem_dest = 5; mem_wb_en = 1; mem_mem_rd = 1; mem_rdy = 1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        n_chk++; if (stall !== 0 || opnd2 !== 32'hDEAD_BEEF || fwd_sel2 !== 2'b01) begin
            n_err++; $display("FAIL lu_after got stall=%b %h/%b want 0 deadbeef/01", stall, opnd2, fwd_sel2); end
        n_chk++; if (stall_cnt !== 2) begin n_err++; $display("FAIL lu_cnt got %0d want 2", stall_cnt); end
        adv();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_mem_rd = 1; mem_wb_en = 1; mem_dest = 6; mem_rdy = 0; exe_src1 = 6;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_chk++; if (freeze !== 1 || stall !== 0) begin
                n_err++; $display("FAIL wait cyc %0d got freeze=%b stall=%b want 1 0", c, freeze, stall); end
            adv();
        end
        mem_rdy = 1; mem_rdata = 32'h1234_5678;
        settle();
        n_chk++; if (freeze !== 0 || opnd1 !== 32'h1234_5678 || fwd_sel1 !== 2'b01) begin
            n_err++; $display("FAIL wait_rdy got freeze=%b %h/%b want 0 12345678/01", freeze, opnd1, fwd_sel1); end
        adv();
        idle();
        settle();
        n_chk++; if (stall_cnt !== 3) begin n_err++; $display("FAIL wait_cnt got %0d want 3", stall_cnt); end
    endtask

    task automatic test_stall_only();
        do_reset();
        fwd_en = 0; id_valid = 1; id_src1 = 7;
        mem_dest = 7; mem_wb_en = 1; mem_alu = 32'h77; exe_src1 = 7;
        settle();
        n_chk++; if (stall !== 1 || fwd_sel1 !== 2'b00 || opnd1 !== rf_rdata1) begin
            n_err++; $display("FAIL so_hazard got stall=%b %b/%h want 1 00/%h", stall, fwd_sel1, opnd1, rf_rdata1); end
        adv();
        mem_wb_en = 0; wb_dest = 7; wb_wb_en = 1; wb_data = 32'h77;
        settle();
        n_chk++; if (stall !== 0 || fwd_sel1 !== 2'b00) begin
            n_err++; $display("FAIL so_retired got stall=%b sel=%b want 0 00", stall, fwd_sel1); end
        adv();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        mem_mem_rd = 1; mem_wb_en = 1; mem_dest = 2; mem_rdy = 0;
        adv();
        adv();
        rst = 0;
        adv();
        idle();
        settle();
        n_chk++; if (freeze !== 0 || stall !== 0 || stall_cnt !== 0) begin
            n_err++; $display("FAIL rst_wait got freeze=%b stall=%b cnt=%0d want 0 0 0", freeze, stall, stall_cnt); end
        adv();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_mem_rd = 1; mem_wb_en = 1; mem_dest = 9; mem_rdy = 0;
        for (int c = 0; c < 20; c++) adv();
        settle();
        n_chk++; if (stall_cnt !== 4'hF || freeze !== 1) begin
            n_err++; $display("FAIL sat got cnt=%0d freeze=%b want 15 1", stall_cnt, freeze); end
        adv();
        idle();
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 59) != 0);
            fwd_en       = ($urandom_range(0, 3) != 0);
            id_valid     = $urandom_range(0, 1);
            id_use_src2  = $urandom_range(0, 1);
            exe_use_src2 = $urandom_range(0, 1);
            exe_wb_en    = $urandom_range(0, 1);
            exe_mem_rd   = $urandom_range(0, 1);
            mem_wb_en    = $urandom_range(0, 1);
            mem_mem_rd   = $urandom_range(0, 1);
            mem_rdy      = ($urandom_range(0, 2) != 0);
            wb_wb_en     = $urandom_range(0, 1);
            id_src1  = 5'($urandom_range(0, 3)); id_src2  = 5'($urandom_range(0, 3));
            exe_src1 = 5'($urandom_range(0, 3)); exe_src2 = 5'($urandom_range(0, 3));
            exe_dest = 5'($urandom_range(0, 3)); mem_dest = 5'($urandom_range(0, 3));
            wb_dest  = 5'($urandom_range(0, 3));
            mem_alu = $urandom; mem_rdata = $urandom; wb_data = $urandom;
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            settle();
            n_chk++; if (opnd1 !== e_op1) begin n_err++; $display("FAIL rnd_opnd1 cyc %0d got %h want %h", c, opnd1, e_op1); end
            n_chk++; if (opnd2 !== e_op2) begin n_err++; $display("FAIL rnd_opnd2 cyc %0d got %h want %h", c, opnd2, e_op2); end
            n_chk++; if (store_data !== e_st) begin n_err++; $display("FAIL rnd_store cyc %0d got %h want %h", c, store_data, e_st); end
            n_chk++; if (fwd_sel1 !== e_sel1) begin n_err++; $display("FAIL rnd_sel1 cyc %0d got %b want %b", c, fwd_sel1, e_sel1); end
            n_chk++; if (fwd_sel2 !== e_sel2) begin n_err++; $display("FAIL rnd_sel2 cyc %0d got %b want %b", c, fwd_sel2, e_sel2); end
            n_chk++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, stall, e_stall); end
            n_chk++; if (freeze !== e_freeze) begin n_err++; $display("FAIL rnd_freeze cyc %0d got %b want %b", c, freeze, e_freeze); end
            n_chk++; if (stall_cnt !== CW'(exp_cnt)) begin
                n_err++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, stall_cnt, exp_cnt); end
            adv();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_mem_fwd();
        test_priority();
        test_load_use();
        test_mem_wait();
        test_stall_only();
        test_reset_in_wait();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
